// File: rtl/id_switch_pkg.sv
// Shared register map and constants for the switch/ID strap bank.
package id_switch_pkg;

  // Register select is address >> 8; only the low three select bits name a register.
  typedef enum logic [2:0] {
    REG_DEBOUNCED    = 3'h0,
    REG_RAW_SYNC     = 3'h1,
    REG_STICKY       = 3'h2,
    REG_CHANGE_COUNT = 3'h3,
    REG_IRQ_MASK     = 3'h4,
    REG_CTRL         = 3'h5,
    REG_ID           = 3'h6,
    REG_SCRATCH      = 3'h7
  } reg_sel_e;

  localparam logic [31:0] DEFAULT_READ    = 32'hDEAD_BEEF;
  localparam int unsigned CTRL_BYPASS_BIT = 0;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/id_switch_debounce.sv
// One switch bit: two-flop synchroniser followed by a stable-count debouncer.
module id_switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic bypass,
  output logic debounced,
  output logic raw_sync
);

  localparam int unsigned COUNT_WIDTH = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                   meta;
  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta     <= 1'b0;
      raw_sync <= 1'b0;
    end else begin
      meta     <= raw;
      raw_sync <= meta;
    end
  end

  // The counter tallies consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      debounced <= 1'b0;
      count     <= '0;
    end else if (bypass) begin
      debounced <= raw_sync;
      count     <= '0;
    end else if (raw_sync == debounced) begin
      count <= '0;
    end else if (count == COUNT_LAST) begin
      debounced <= raw_sync;
      count     <= '0;
    end else begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/id_switch_bank.sv
// Avalon-MM slave exposing debounced board switches / ID straps with sticky
// change bits, a saturating change counter and a maskable level interrupt.
module id_switch_bank
  import id_switch_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] ID_VALUE        = 32'h1D5C_0001,
  parameter int unsigned ADDR_WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] avalon_slave_address,
  input  logic                  avalon_slave_write,
  input  logic [31:0]           avalon_slave_writedata,
  input  logic                  avalon_slave_read,
  output logic [31:0]           avalon_slave_readdata,
  output logic                  avalon_slave_waitrequest,
  input  logic [SW_WIDTH-1:0]   SW,
  output logic                  irq
);

  localparam int unsigned SEL_WIDTH = ADDR_WIDTH - 8;

  logic [SW_WIDTH-1:0]  debounced;
  logic [SW_WIDTH-1:0]  raw_sync;
  logic [SW_WIDTH-1:0]  debounced_prev;
  logic [SW_WIDTH-1:0]  change;
  logic [SW_WIDTH-1:0]  sticky;
  logic [SW_WIDTH-1:0]  sticky_clear;
  logic [SW_WIDTH-1:0]  mask;
  logic                 bypass;
  logic [31:0]          change_count;
  logic [31:0]          scratch;
  logic [31:0]          read_value;
  logic                 any_change;
  logic                 wait_flag;

  logic [SEL_WIDTH-1:0] sel;
  logic                 sel_in_map;
  reg_sel_e             reg_sel;
  logic                 write_en;
  logic                 write_sticky;
  logic                 write_count;
  logic                 write_mask;
  logic                 write_ctrl;
  logic                 write_scratch;
  logic                 unused_address;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
    id_switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock    (clock),
      .reset    (reset),
      .raw      (SW[i]),
      .bypass   (bypass),
      .debounced(debounced[i]),
      .raw_sync (raw_sync[i])
    );
  end

  assign sel            = avalon_slave_address[ADDR_WIDTH-1:8];
  assign sel_in_map     = (sel >> 3) == '0;
  assign reg_sel        = reg_sel_e'(sel[2:0]);
  assign unused_address = ^avalon_slave_address[7:0];

  // A write coinciding with a read is dropped so the read sees a stable map.
  always_comb begin
    write_en      = avalon_slave_write && !avalon_slave_read && sel_in_map;
    write_sticky  = 1'b0;
    write_count   = 1'b0;
    write_mask    = 1'b0;
    write_ctrl    = 1'b0;
    write_scratch = 1'b0;
    if (write_en) begin
      case (reg_sel)
        REG_STICKY:       write_sticky  = 1'b1;
        REG_CHANGE_COUNT: write_count   = 1'b1;
        REG_IRQ_MASK:     write_mask    = 1'b1;
        REG_CTRL:         write_ctrl    = 1'b1;
        REG_SCRATCH:      write_scratch = 1'b1;
        default:          ;
      endcase
    end
  end

  always_comb begin
    change       = debounced ^ debounced_prev;
    any_change   = |change;
    sticky_clear = write_sticky ? avalon_slave_writedata[SW_WIDTH-1:0] : '0;
  end

  // Set-after-clear ordering lets a same-cycle change win over W1C, and a
  // same-cycle increment survive a count clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      debounced_prev <= '0;
      sticky         <= '0;
      change_count   <= '0;
      mask           <= '0;
      bypass         <= 1'b0;
      scratch        <= '0;
      irq            <= 1'b0;
    end else begin
      debounced_prev <= debounced;
      sticky         <= (sticky & ~sticky_clear) | change;
      if (write_count) begin
        change_count <= any_change ? 32'd1 : '0;
      end else if (any_change) begin
        change_count <= sat_inc(change_count);
      end
      if (write_mask) begin
        mask <= avalon_slave_writedata[SW_WIDTH-1:0];
      end
      if (write_ctrl) begin
        bypass <= avalon_slave_writedata[CTRL_BYPASS_BIT];
      end
      if (write_scratch) begin
        scratch <= avalon_slave_writedata;
      end
      irq <= |(sticky & mask);
    end
  end

  always_comb begin
    read_value = DEFAULT_READ;
    if (sel_in_map) begin
      case (reg_sel)
        REG_DEBOUNCED: begin
          read_value                = '0;
          read_value[SW_WIDTH-1:0]  = debounced;
        end
        REG_RAW_SYNC: begin
          read_value                = '0;
          read_value[SW_WIDTH-1:0]  = raw_sync;
        end
        REG_STICKY: begin
          read_value                = '0;
          read_value[SW_WIDTH-1:0]  = sticky;
        end
        REG_CHANGE_COUNT: read_value = change_count;
        REG_IRQ_MASK: begin
          read_value                = '0;
          read_value[SW_WIDTH-1:0]  = mask;
        end
        REG_CTRL: begin
          read_value                  = '0;
          read_value[CTRL_BYPASS_BIT] = bypass;
        end
        REG_ID:       read_value = ID_VALUE;
        REG_SCRATCH:  read_value = scratch;
        default:      read_value = DEFAULT_READ;
      endcase
    end
  end

  // wait_flag arms the single wait state; it re-arms after every completed
  // read and whenever read drops, so each read costs exactly two cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_flag             <= 1'b1;
      avalon_slave_readdata <= '0;
    end else if (avalon_slave_read && wait_flag) begin
      wait_flag             <= 1'b0;
      avalon_slave_readdata <= read_value;
    end else begin
      wait_flag <= 1'b1;
    end
  end

  assign avalon_slave_waitrequest = wait_flag && avalon_slave_read && !reset;

endmodule

// File: tb/tb_id_switch_bank.sv
// Scoreboard bench for id_switch_bank: reads push expected data, a negedge
// monitor pops and compares whenever a read completes.
module tb_id_switch_bank;

  localparam logic [31:0] ID = 32'h1D5C_0001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [3:0]  sw = '0;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t        sb[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clock = ~clock;

  id_switch_bank #(
    .SW_WIDTH       (4),
    .DEBOUNCE_CYCLES(4),
    .ID_VALUE       (ID),
    .ADDR_WIDTH     (16)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .avalon_slave_address    (address),
    .avalon_slave_write      (write),
    .avalon_slave_writedata  (writedata),
    .avalon_slave_read       (read),
    .avalon_slave_readdata   (readdata),
    .avalon_slave_waitrequest(waitrequest),
    .SW                      (sw),
    .irq                     (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && read && !waitrequest) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_read: got %08h expected no read data", readdata);
      end else begin
        e = sb.pop_front();
        check(e.name, readdata, e.value);
      end
    end
  end

  // Called at posedge+2; capture happens on the next posedge, returns at posedge+2
  // two cycles later with read still high so reads can run back to back.
  task automatic do_read(input logic [15:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    int   n;
    bit   done;
    e.name  = name;
    e.value = exp;
    sb.push_back(e);
    address = addr;
    read    = 1'b1;
    n       = 0;
    done    = 1'b0;
    while (!done && n < 10) begin
      @(negedge clock);
      if (waitrequest) n++;
      else done = 1'b1;
    end
    if (!done) begin
      total++;
      $display("FAIL %s_timeout: waitrequest stuck high, required low within 10 cycles", name);
      void'(sb.pop_back());
    end else begin
      check({name, "_wait"}, 32'(n), 32'd1);
    end
    @(posedge clock);
    #2;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data);
    read      = 1'b0;
    address   = addr;
    writedata = data;
    write     = 1'b1;
    @(posedge clock);
    #2;
    write = 1'b0;
  endtask

  task automatic wait_cycles(input int unsigned n);
    read = 1'b0;
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #2;
    check("reset_waitrequest", {31'b0, waitrequest}, 32'h0);

    do_read(16'h0600, ID, "id");
    do_read(16'h0900, 32'hDEAD_BEEF, "unmapped");
    do_read(16'h0000, 32'h0, "deb_reset");
    do_read(16'h0200, 32'h0, "sticky_reset");
    do_read(16'h0300, 32'h0, "count_reset");

    // Debounce latency: sync at +2, debounced flips on the 6th edge after the change.
    sw = 4'b0101;
    wait_cycles(3);
    do_read(16'h0100, 32'h5, "raw_sync");
    do_read(16'h0000, 32'h0, "deb_not_early");
    do_read(16'h0000, 32'h5, "deb_settled");
    do_read(16'h0200, 32'h5, "sticky_set");
    do_read(16'h0300, 32'h1, "count_one");

    // Two-cycle glitch on SW[3] must be filtered.
    sw = 4'b1101;
    wait_cycles(2);
    sw = 4'b0101;
    wait_cycles(10);
    do_read(16'h0000, 32'h5, "glitch_deb");
    do_read(16'h0200, 32'h5, "glitch_sticky");
    do_read(16'h0300, 32'h1, "glitch_count");

    do_write(16'h0400, 32'h1);
    check("irq_latency", {31'b0, irq}, 32'h0);
    wait_cycles(1);
    check("irq_set", {31'b0, irq}, 32'h1);
    do_write(16'h0200, 32'h1);
    wait_cycles(1);
    check("irq_clear", {31'b0, irq}, 32'h0);
    do_read(16'h0200, 32'h4, "sticky_w1c");

    // SW[0] debounced fall lands on the same edge as a W1C of bit 0.
    sw = 4'b0100;
    wait_cycles(6);
    do_write(16'h0200, 32'h1);
    do_read(16'h0200, 32'h5, "set_beats_clear");
    do_read(16'h0300, 32'h2, "count_two");
    check("irq_after_collision", {31'b0, irq}, 32'h1);

    // SW[0] rise lands on the same edge as a count clear.
    sw = 4'b0101;
    wait_cycles(6);
    do_write(16'h0300, 32'h0);
    do_read(16'h0300, 32'h1, "clear_vs_inc");

    do_write(16'h0500, 32'h3);
    do_read(16'h0500, 32'h1, "ctrl_bypass");
    sw = 4'b0111;
    wait_cycles(2);
    do_read(16'h0000, 32'h5, "bypass_before");
    do_read(16'h0000, 32'h7, "bypass_fast");
    do_write(16'h0300, 32'h0);
    do_read(16'h0300, 32'h0, "count_cleared");
    for (int i = 0; i < 10; i++) begin
      sw[1] = ~sw[1];
      wait_cycles(2);
    end
    wait_cycles(4);
    do_read(16'h0300, 32'd10, "bypass_count");
    do_read(16'h0000, 32'h7, "bypass_deb");
    do_read(16'h0200, 32'h7, "bypass_sticky");

    do_write(16'h0700, 32'hA5A5_A5A5);
    do_read(16'h0000, 32'h7, "b2b_deb");
    do_read(16'h0700, 32'hA5A5_A5A5, "b2b_scratch");
    writedata = 32'h1234_5678;
    write     = 1'b1;
    do_read(16'h0700, 32'hA5A5_A5A5, "wr_rd_same");
    write = 1'b0;
    do_read(16'h0700, 32'hA5A5_A5A5, "scratch_kept");
    do_write(16'h0900, 32'h0000_0000);
    do_read(16'h0900, 32'hDEAD_BEEF, "unmapped_wr");
    do_read(16'h0400, 32'h1, "mask_rb");

    // Reset during the wait state of a read.
    wait_cycles(1);
    address = 16'h0700;
    read    = 1'b1;
    @(negedge clock);
    check("wait_before_reset", {31'b0, waitrequest}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("reset_mid_wait", {31'b0, waitrequest}, 32'h0);
    check("reset_mid_readdata", readdata, 32'h0);
    check("reset_mid_irq", {31'b0, irq}, 32'h0);
    read = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #2;
    do_read(16'h0700, 32'h0, "post_scratch");
    do_read(16'h0500, 32'h0, "post_ctrl");
    do_read(16'h0200, 32'h0, "post_sticky_early");
    do_read(16'h0400, 32'h0, "post_mask");
    wait_cycles(4);
    do_read(16'h0000, 32'h7, "post_deb");
    do_read(16'h0200, 32'h7, "post_sticky");
    do_read(16'h0300, 32'h1, "post_count");
    wait_cycles(2);

    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending reads expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_switch_bank.md
Name: id_switch_bank

Overview:
Parametrised Avalon-MM slave that exposes a bank of board switches/ID straps to the HPS via the lightweight AXI bridge. Each switch bit is synchronised and debounced. Toggles are latched into sticky bits and counted, and a level interrupt is raised for unmasked changes. The register-read handshake inserts exactly one wait state, replacing the single-value stub interface.

Parameters:
SW_WIDTH, 4, number of switch inputs (1..32)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced value changes (>=1)
ID_VALUE, 32'h1D5C_0001, constant returned by the ID register
ADDR_WIDTH, 16, Avalon address width; register select = address>>8

Ports:
clock  in  1  system clock
reset  in  1  reset, asynchronous, active-high
avalon_slave_address  in  ADDR_WIDTH  word address; bits [ADDR_WIDTH-1:8] select the register
avalon_slave_write  in  1  write strobe
avalon_slave_writedata  in  32  write data
avalon_slave_read  in  1  read strobe
avalon_slave_readdata  out  32  read data, valid when read=1 and waitrequest=0
avalon_slave_waitrequest  out  1  stall for reads
SW  in  SW_WIDTH  raw asynchronous switch inputs
irq  out  1  level interrupt: |(sticky & mask)

Behaviour:
- Reset values:
  - readdata=0; waitrequest=0 (internal wait flag=1, read=0).
  - irq=0; sync/debounced=0; sticky=0; counter=0; mask=0; ctrl=0; scratch=0.
  - Debounced value starts at 0, so switches held high at reset produce a change after debounce.
- Synchroniser: 2-FF per bit; the raw-sync value lags SW by 2 cycles.
- Debounce (per bit):
  - Counter clears whenever sync==debounced.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 the debounced bit takes the sync value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
  - ctrl[0]=1 (bypass): debounced<=sync every cycle and counters are held at 0.
- Change detect: a debounced bit differing from its previous-cycle value sets sticky[i]. The change counter increments by 1 per cycle in which any bit changes, saturating at 32'hFFFFFFFF.
- Register map (address>>8):
  - 0x00 debounced (RO, zero-extended)
  - 0x01 raw sync (RO)
  - 0x02 sticky (RW1C)
  - 0x03 change count (RO; any write clears it to 0)
  - 0x04 irq mask (RW, SW_WIDTH bits)
  - 0x05 ctrl (RW, bit0 bypass, other bits read 0)
  - 0x06 ID_VALUE (RO)
  - 0x07 scratch (RW 32 bits)
  - all other selects read 32'hDEADBEEF; writes to them are ignored.
- Read handshake:
  - waitrequest = wait_flag && read.
  - Cycle N, read=1, wait_flag=1: readdata captured from the addressed register, wait_flag<=0. waitrequest is high in N and low in N+1, where the master samples readdata.
  - In a cycle with read=1 and wait_flag=0, wait_flag<=1, so back-to-back reads take 2 cycles each.
  - read dropped mid-transaction: wait_flag returns to 1 next cycle and readdata holds its value.
- Writes: zero wait states, accepted in any cycle with write=1 and read=0; write and read together: the write is ignored.
- Simultaneous events:
  - A set from a new change beats a W1C clear on the same bit in the same cycle.
  - Count-clear write and an increment in the same cycle give 1.
- irq is registered: it follows sticky/mask with 1 cycle latency.
- Asynchronous reset mid-read forces waitrequest low immediately and aborts the transaction.

Decomposition:
- Shared package id_switch_pkg: register-select constants (REG_DEBOUNCED..REG_SCRATCH), DEFAULT_READ=32'hDEADBEEF, CTRL_BYPASS_BIT=0.
- One natural sub-module: id_switch_debounce (single bit: synchroniser plus counter, parameter DEBOUNCE_CYCLES, output debounced bit plus raw sync bit), instantiated SW_WIDTH times with generate.

Test Plan:
- SW_WIDTH=4, DEBOUNCE_CYCLES=4. After reset, read 0x0600 -> waitrequest high 1 cycle, then readdata=ID_VALUE; read 0x0900 -> 32'hDEADBEEF.
- SW=4'b0101 held steady -> debounced reads 0x5 no earlier than 2+4 cycles after the change; sticky=0x5; count=1. A 2-cycle pulse on SW[3] -> no change to debounced, sticky or count.
- mask=0x1, sticky bit0 set -> irq=1 one cycle later; write 0x1 to 0x0200 -> sticky=0x4, irq=0; a same-cycle SW[0] debounced toggle during the clear leaves sticky[0]=1.
- ctrl=1 (bypass), SW toggles every 2 cycles 10 times -> count=10 and debounced tracks sync with no delay beyond the 2-cycle synchroniser.
- Back-to-back reads of 0x0000 and 0x0700 with scratch=0xA5A5A5A5 -> each read takes 2 cycles with correct data; write+read in the same cycle to 0x0700 -> scratch unchanged.
- Assert reset during the wait state of a read -> waitrequest=0 immediately, all registers return to reset values, and the next read completes normally.
